// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, types and round-key packing helper
package aes_pkg;
  localparam int KEY_W = 128;
  localparam int WORD_W = 32;
  localparam int NR = 10;
  localparam logic [3:0] LAST = 4'(NR);
  typedef enum logic {IDLE, EXPAND} state_t;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 40'h0
  };
  function automatic int rk_lsb(input logic [3:0] i);
    return KEY_W * int'(i);
  endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: four parallel S-box lookups on a 32-bit word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sub
);
  // byte-wise substitution, MSB byte first
  always_comb sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: sequential AES-128 key schedule, one round key per cycle
module aes_key_expand
  import aes_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KEY_W-1:0]          key_in,
  input  logic                      key_valid,
  output logic                      key_ready,
  output logic                      rk_valid,
  output logic [3:0]                rk_index,
  output logic [KEY_W-1:0]          rk_out,
  output logic [KEY_W*(NR+1)-1:0]   round_keys,
  output logic                      keys_valid,
  output logic                      done
);
  state_t state, state_next;
  logic [KEY_W-1:0] w, w_next;
  logic [3:0] idx;
  logic [WORD_W-1:0] rot, sub, t, w0n, w1n, w2n, w3n;
  logic accept, step, last;
  logic [NR:0] we;
  assign rot = {w[23:0], w[31:24]};
  aes_sub_word u_sub (.word(rot), .sub(sub));
  // next round key from the current one
  always_comb begin
    t = sub ^ {RCON[idx + 4'd1], 24'h0};
    w0n = w[127:96] ^ t;
    w1n = w[95:64] ^ w0n;
    w2n = w[63:32] ^ w1n;
    w3n = w[31:0] ^ w2n;
    w_next = {w0n, w1n, w2n, w3n};
  end
  // handshake, step control and next state
  always_comb begin
    last = state == EXPAND && idx == LAST;
    accept = state == IDLE && key_valid;
    step = state == EXPAND && idx != LAST;
    state_next = accept ? EXPAND : last ? IDLE : state;
  end
  assign key_ready = state == IDLE;
  assign rk_valid = state == EXPAND;
  assign rk_index = idx;
  assign rk_out = w;
  assign done = last;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  // working key and round counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w <= '0;
      idx <= '0;
    end else if (accept) begin
      w <= key_in;
      idx <= '0;
    end else if (step) begin
      w <= w_next;
      idx <= idx + 4'd1;
    end
  // packed-bus slice enables decoded from the round counter
  always_comb begin
    we = '0;
    for (int i = 0; i <= NR; i++) we[i] = i == 0 ? accept : step && idx == 4'(i - 1);
  end
  // packed round-key bus
  always_ff @(posedge clk or posedge rst)
    if (rst) round_keys <= '0;
    else for (int i = 0; i <= NR; i++) if (we[i]) round_keys[rk_lsb(4'(i)) +: KEY_W] <= i == 0 ? key_in : w_next;
  // schedule-complete flag, cleared by a new key
  always_ff @(posedge clk or posedge rst)
    if (rst) keys_valid <= 1'b0;
    else if (accept) keys_valid <= 1'b0;
    else if (last) keys_valid <= 1'b1;
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: scoreboard bench for the AES-128 key schedule
module tb_aes_key_expand;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic key_ready, rk_valid, keys_valid, done;
  logic [3:0] rk_index;
  logic [127:0] rk_out;
  logic [1407:0] round_keys;
  typedef struct {logic [3:0] idx; logic [127:0] key;} beat_t;
  beat_t sb_q[$];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  logic [7:0] sb[256];
  logic [127:0] exp_rk[11], obs[11];

  aes_key_expand dut (.clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .rk_valid(rk_valid), .rk_index(rk_index), .rk_out(rk_out),
    .round_keys(round_keys), .keys_valid(keys_valid), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x, y;
    r = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic void init_sbox();
    logic [7:0] inv;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      d = {inv, inv};
      sb[x] = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    end
  endfunction

  function automatic void model_expand(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0] rc;
    {w0, w1, w2, w3} = k;
    rc = 8'h01;
    exp_rk[0] = k;
    for (int r = 1; r <= 10; r++) begin
      t = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      exp_rk[r] = {w0, w1, w2, w3};
      rc = xt(rc);
    end
  endfunction

  function automatic logic [1407:0] pack_rk();
    logic [1407:0] p;
    for (int i = 0; i < 11; i++) p[128*i +: 128] = exp_rk[i];
    return p;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [1407:0] rks);
    logic [127:0] s;
    logic [7:0] a[16], b[16], m[4];
    s = pt ^ rks[127:0];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) a[k] = sb[s[127-8*k -: 8]];
      for (int c = 0; c < 4; c++) for (int q = 0; q < 4; q++) b[4*c+q] = a[4*((c+q)%4)+q];
      if (r < 10) for (int c = 0; c < 4; c++) begin
        for (int q = 0; q < 4; q++)
          m[q] = xt(b[4*c+q]) ^ xt(b[4*c+(q+1)%4]) ^ b[4*c+(q+1)%4] ^ b[4*c+(q+2)%4] ^ b[4*c+(q+3)%4];
        for (int q = 0; q < 4; q++) b[4*c+q] = m[q];
      end
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = b[k];
      s = s ^ rks[128*r +: 128];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_key(input logic [127:0] k, input bit hold);
    int n = 0;
    key_in = k;
    key_valid = 1'b1;
    while (!key_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: key_ready=%b required 1", key_ready);
    end
    model_expand(k);
    for (int i = 0; i < 11; i++) sb_q.push_back('{idx: 4'(i), key: exp_rk[i]});
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) key_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit fin);
    int got = 0, budget = 0;
    beat_t e;
    while (got < n && budget < 40) begin
      if (rk_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: unexpected beat idx=%0d", rk_index);
        end else begin
          e = sb_q.pop_front();
          if (rk_index !== e.idx || rk_out !== e.key) begin
            errors++;
            $display("FAIL beat: idx=%0d key=%h required idx=%0d key=%h", rk_index, rk_out, e.idx, e.key);
          end
          checks++;
          if (cyc !== acc_cyc + int'(e.idx)) begin
            errors++;
            $display("FAIL beat_cycle: idx=%0d at cycle %0d required %0d", e.idx, cyc, acc_cyc + int'(e.idx));
          end
          checks++;
          if (done !== (e.idx == 4'd10)) begin
            errors++;
            $display("FAIL done: idx=%0d done=%b required %b", e.idx, done, e.idx == 4'd10);
          end
          checks++;
          if (key_ready !== 1'b0 || keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_flags: key_ready=%b keys_valid=%b required 0 0", key_ready, keys_valid);
          end
          obs[e.idx] = rk_out;
        end
        got++;
      end
      budget++;
      if (got < n) @(negedge clk);
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL collect_timeout: got %0d beats required %0d", got, n);
    end
    if (fin) begin
      @(negedge clk);
      checks++;
      if (rk_valid !== 1'b0 || done !== 1'b0 || key_ready !== 1'b1 || keys_valid !== 1'b1) begin
        errors++;
        $display("FAIL end_flags: rk_valid=%b done=%b key_ready=%b keys_valid=%b required 0 0 1 1",
          rk_valid, done, key_ready, keys_valid);
      end
      checks++;
      if (cyc !== acc_cyc + 11) begin
        errors++;
        $display("FAIL ready_cycle: cycle %0d required %0d", cyc, acc_cyc + 11);
      end
      checks++;
      if (round_keys !== pack_rk()) begin
        errors++;
        $display("FAIL round_keys: slice10=%h required %h", round_keys[1407:1280], exp_rk[10]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || done !== 1'b0 || keys_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b rk_valid=%b done=%b keys_valid=%b required 1 0 0 0",
        key_ready, rk_valid, done, keys_valid);
    end
    checks++;
    if (rk_index !== 4'd0 || rk_out !== '0 || round_keys !== '0) begin
      errors++;
      $display("FAIL reset_data: rk_index=%0d rk_out=%h required 0 0 and zero round_keys", rk_index, rk_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips();
    send_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    collect(11, 1'b1);
    checks++;
    if (obs[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++;
      $display("FAIL fips_rk1: %h required a0fafe1788542cb123a339392a6c7605", obs[1]);
    end
    checks++;
    if (obs[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL fips_rk10: %h required d014f9a8c9ee2589e13f0cc8b6630ca6", obs[10]);
    end
  endtask

  task automatic test_loopback();
    logic [127:0] ct;
    ct = aes_enc(128'h3243f6a8885a308d313198a2e0370734, round_keys);
    checks++;
    if (ct !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      errors++;
      $display("FAIL loopback: ct=%h required 3925841d02dc09fbdc118597196a0b32", ct);
    end
  endtask

  task automatic test_zero_key();
    send_key('0, 1'b0);
    collect(11, 1'b1);
    checks++;
    if (obs[1] !== 128'h62636363626363636263636362636363) begin
      errors++;
      $display("FAIL zero_rk1: %h required 62636363626363636263636362636363", obs[1]);
    end
    checks++;
    if (obs[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      errors++;
      $display("FAIL zero_rk10: %h required b4ef5bcb3e92e21123e951cf6f8f188e", obs[10]);
    end
  endtask

  task automatic test_cycles();
    int nv = 0;
    logic [3:0] ei = '0;
    send_key(rand_key(), 1'b0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (rk_valid !== (i < 11) || key_ready !== (i == 11)) begin
        errors++;
        $display("FAIL cyc_flags: T+%0d rk_valid=%b key_ready=%b required %b %b",
          i + 1, rk_valid, key_ready, i < 11, i == 11);
      end
      if (rk_valid) begin
        checks++;
        if (rk_index !== ei) begin
          errors++;
          $display("FAIL cyc_index: T+%0d rk_index=%0d required %0d", i + 1, rk_index, ei);
        end
        ei++;
        nv++;
      end
      @(negedge clk);
    end
    checks++;
    if (nv != 11) begin
      errors++;
      $display("FAIL cyc_count: %0d valid beats required 11", nv);
    end
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [127:0] kb;
    kb = rand_key();
    send_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    key_in = kb;
    collect(11, 1'b1);
    send_key(kb, 1'b0);
    collect(11, 1'b1);
  endtask

  task automatic test_reset_mid();
    send_key(rand_key(), 1'b0);
    collect(6, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (rk_valid !== 1'b0 || keys_valid !== 1'b0 || done !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_flags: rk_valid=%b keys_valid=%b done=%b ready=%b required 0 0 0 1",
        rk_valid, keys_valid, done, key_ready);
    end
    checks++;
    if (round_keys !== '0) begin
      errors++;
      $display("FAIL mid_reset_bus: slice0=%h required 0", round_keys[127:0]);
    end
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_key(rand_key(), 1'b0);
    collect(11, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      send_key(rand_key(), 1'b0);
      collect(11, 1'b1);
    end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_fips();
    test_loopback();
    test_zero_key();
    test_cycles();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
